// File: rtl/eth_tx_arbiter_if.sv
// Bundle of signals between the three frame sources, the TX arbiter and
// the rmii_tx byte-stream MAC.
//   src_req/src_data/src_valid/src_last : source side, into the arbiter
//   src_ready/src_gnt                   : source side, out of the arbiter
//   mac_start/mac_data/mac_valid/mac_last : arbiter to MAC
//   mac_ready/mac_busy                  : MAC back to arbiter
// The master modport belongs to the arbiter. The slave modport is the
// environment side, meaning the sources plus the MAC.
interface eth_tx_arbiter_if;
  logic [2:0]  src_req;
  logic [23:0] src_data;
  logic [2:0]  src_valid;
  logic [2:0]  src_last;
  logic [2:0]  src_ready;
  logic [2:0]  src_gnt;
  logic        mac_start;
  logic [7:0]  mac_data;
  logic        mac_valid;
  logic        mac_last;
  logic        mac_ready;
  logic        mac_busy;

  modport master (
    input  src_req, src_data, src_valid, src_last, mac_ready, mac_busy,
    output src_ready, src_gnt, mac_start, mac_data, mac_valid, mac_last
  );

  modport slave (
    output src_req, src_data, src_valid, src_last, mac_ready, mac_busy,
    input  src_ready, src_gnt, mac_start, mac_data, mac_valid, mac_last
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin TX arbiter. It shares one rmii_tx MAC between three frame
// sources: ARP reply (0), UDP echo (1) and hello/telemetry (2).
// It grants one source per frame and pulses mac_start. It then passes the
// granted byte stream through, waits for the MAC to go idle, and enforces
// the inter-frame gap before the next grant. A watchdog aborts a frame
// whose source stops supplying bytes.
// Ports:
//   clk50, rst_n : clock, asynchronous active-low reset
//   bus          : source/MAC handshake bundle (master modport)
//   frames_sent  : frames completed normally (wraps)
//   abort_count  : watchdog aborts (saturates at 255)
//   err_timeout  : one-cycle pulse, the cycle after an abort byte is accepted
module eth_tx_arbiter #(
  parameter int IFG_CYCLES     = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk50,
  input  logic             rst_n,
  eth_tx_arbiter_if.master bus,
  output logic [15:0]      frames_sent,
  output logic [7:0]       abort_count,
  output logic             err_timeout
);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, XFER, DRAIN, IFG} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       rr_reg, rr_next;
  logic [1:0]       idx_reg, idx_next;
  logic [2:0]       gnt_reg, gnt_next;
  logic [WD_W-1:0]  wd_reg, wd_next;
  logic [IFG_W-1:0] ifg_reg, ifg_next;
  logic [15:0]      frames_reg, frames_next;
  logic [7:0]       abort_reg, abort_next;
  logic             err_reg, err_next;

  logic [7:0] src_byte [3];
  logic [1:0] cand [3];
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       in_xfer;
  logic       abort_now;
  logic       xfer_fire;

  assign in_xfer   = (state_reg == XFER);
  // Once the watchdog reaches its limit, the arbiter owns the byte lane
  // until the MAC accepts the abort byte.
  assign abort_now = in_xfer && (wd_reg == WD_LIMIT);

  // cand[k] is the k-th index in scan order, starting at rr_reg and wrapping 2->0.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      logic [2:0] sum;
      assign src_byte[gi]      = bus.src_data[8*gi +: 8];
      assign sum               = {1'b0, rr_reg} + 3'(gi);
      assign cand[gi]          = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      assign bus.src_ready[gi] = in_xfer && !abort_now && gnt_reg[gi] && bus.mac_ready;
    end
  endgenerate

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!pick_found && bus.src_req[cand[k]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[k];
      end
    end
  end

  // MAC-side outputs: pass-through in XFER, forced abort byte, zero elsewhere.
  always_comb begin
    bus.mac_start = (state_reg == START);
    bus.mac_data  = 8'h00;
    bus.mac_valid = 1'b0;
    bus.mac_last  = 1'b0;
    if (abort_now) begin
      bus.mac_valid = 1'b1;
      bus.mac_last  = 1'b1;
    end else if (in_xfer) begin
      bus.mac_data  = src_byte[idx_reg];
      bus.mac_valid = bus.src_valid[idx_reg];
      bus.mac_last  = bus.src_last[idx_reg];
    end
  end

  assign xfer_fire   = bus.mac_valid && bus.mac_ready;
  assign bus.src_gnt = gnt_reg;
  assign frames_sent = frames_reg;
  assign abort_count = abort_reg;
  assign err_timeout = err_reg;

  always_comb begin
    state_next  = state_reg;
    rr_next     = rr_reg;
    idx_next    = idx_reg;
    gnt_next    = gnt_reg;
    wd_next     = wd_reg;
    ifg_next    = ifg_reg;
    frames_next = frames_reg;
    abort_next  = abort_reg;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found && !bus.mac_busy) begin
          idx_next   = pick_idx;
          gnt_next   = 3'b001 << pick_idx;
          state_next = START;
        end
      end
      START: begin
        wd_next    = '0;
        state_next = XFER;
      end
      XFER: begin
        if (abort_now) begin
          if (bus.mac_ready) begin
            err_next   = 1'b1;
            abort_next = (abort_reg == 8'hFF) ? abort_reg : abort_reg + 8'd1;
            state_next = DRAIN;
          end
        end else if (xfer_fire) begin
          wd_next = '0;
          if (bus.mac_last) begin
            frames_next = frames_reg + 16'd1;
            state_next  = DRAIN;
          end
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.mac_busy) begin
          gnt_next   = 3'b000;
          rr_next    = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
          ifg_next   = IFG_LOAD;
          state_next = IFG;
        end
      end
      IFG: begin
        if (ifg_reg == '0) state_next = IDLE;
        else               ifg_next   = ifg_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_reg     <= 2'd0;
      idx_reg    <= 2'd0;
      gnt_reg    <= 3'b000;
      wd_reg     <= '0;
      ifg_reg    <= '0;
      frames_reg <= 16'd0;
      abort_reg  <= 8'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_reg     <= rr_next;
      idx_reg    <= idx_next;
      gnt_reg    <= gnt_next;
      wd_reg     <= wd_next;
      ifg_reg    <= ifg_next;
      frames_reg <= frames_next;
      abort_reg  <= abort_next;
      err_reg    <= err_next;
    end
  end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single rmii_tx byte-stream MAC between three frame sources: ARP reply (src 0), UDP echo (src 1) and periodic hello/telemetry (src 2).
- Grants one source per frame using round-robin and sequences the MAC start pulse.
- Forwards the granted byte stream, then enforces the Ethernet inter-frame gap before the next grant.
- Adds a stall watchdog so a hung source cannot lock the TX path.

Parameters:
- IFG_CYCLES, 48, idle clk50 cycles after mac_busy falls before the next grant (96 bit times at 100 Mb/s RMII).
- TIMEOUT_CYCLES, 1024, max clk50 cycles without a byte transfer in XFER before abort.

Ports:
- clk50  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- src_req  in  3  per-source frame request (level, held until granted)
- src_data  in  24  packed bytes, src i at [8i+7:8i]
- src_valid  in  3  per-source byte valid
- src_last  in  3  per-source last byte of frame
- src_ready  out  3  per-source byte accepted this cycle
- src_gnt  out  3  one-hot grant, held for the whole frame
- mac_start  out  1  one-cycle frame start to MAC
- mac_data  out  8  byte to MAC
- mac_valid  out  1  byte valid to MAC
- mac_last  out  1  last byte to MAC
- mac_ready  in  1  MAC accepts byte when mac_valid & mac_ready
- mac_busy  in  1  MAC transmitting (incl. preamble/CRC)
- frames_sent  out  16  completed frames, wraps
- abort_count  out  8  watchdog aborts, saturates at 255
- err_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async, rst_n=0): state IDLE, src_gnt=0, rr_ptr=0, all mac_* outputs=0, src_ready=0, counters=0, err_timeout=0.
- FSM states: IDLE, START, XFER, DRAIN, IFG.
- IDLE: when src_req!=0 and !mac_busy, pick the first requesting index starting at rr_ptr, wrapping 2->0. Register the one-hot src_gnt and go to START.
  - Decision is made on the cycle the request is seen; src_gnt is visible the next cycle.
- START: mac_start=1 for exactly one cycle, then go to XFER. src_gnt is held regardless of src_req changes.
- XFER: combinational pass-through from the granted source.
  - mac_data = granted byte, mac_valid = granted src_valid, mac_last = granted src_last.
  - src_ready[g] = mac_ready; all non-granted src_ready bits = 0.
  - A transfer occurs when mac_valid & mac_ready.
  - A transfer with mac_last goes to DRAIN; frames_sent += 1 at that transfer.
- Watchdog: a counter clears on every transfer and on entry to XFER, and increments otherwise.
  - At TIMEOUT_CYCLES-1 the arbiter overrides the source: mac_data=8'h00, mac_valid=1, mac_last=1, src_ready=0, held until mac_ready.
  - On acceptance: err_timeout pulses, abort_count increments (saturating), frames_sent is not incremented, go to DRAIN.
- DRAIN: src_gnt is held; wait for mac_busy=0, then clear src_gnt, set rr_ptr = granted index + 1 (mod 3), load the IFG counter and go to IFG.
- IFG: count IFG_CYCLES cycles with no grant, then go to IDLE.
  - A request already pending is granted on the first IDLE cycle, so minimum start-to-start spacing = frame + IFG_CYCLES + 2.
- Outside XFER: mac_valid=mac_last=0, mac_data=0, src_ready=0.
- A source dropping src_req mid-frame has no effect; the frame completes or times out.
- Simultaneous requests: round-robin only; no fixed priority. Every requester is served within 3 frames.
- mac_busy high in IDLE (MAC not yet idle after reset) blocks the grant.

Test Plan:
- src_req=3'b001 only; src 0 sends 42 bytes, last on byte 42 -> one mac_start pulse, 42 mac transfers with data matching, frames_sent=1, src_gnt=0 after mac_busy falls.
- src_req=3'b111 held, each source sends 10 bytes -> grant order 0,1,2,0; start-to-start gap ≥ 10×4-cycle byte time + 48 + 2 cycles.
- Back-to-back: mac_busy falls at cycle T -> next mac_start not before T+48+2; mac_valid=0 throughout IFG.
- Granted src 1 stops asserting valid after 5 bytes -> after 1024 idle cycles, mac byte 00 with mac_last=1, err_timeout pulse, abort_count=1, frames_sent unchanged, next grant goes to src 2.
- rst_n pulled low mid-XFER -> all outputs 0 asynchronously; after release, a pending src_req=3'b100 is granted to src 2 (rr_ptr=0 scan).
- mac_ready toggled 1/0 every cycle during a 20-byte frame -> exactly 20 transfers, no duplicate or dropped bytes, src_ready mirrors mac_ready.
